// File: rtl/d5m_stream_gen_if.sv
// Stream/control bundle for the synthetic D5M source: run/pattern controls in,
// FVAL/LVAL/pixel raster plus position and frame counters out.
interface d5m_stream_gen_if #(
  parameter int PIXEL_SIZE = 12
) ();
  logic                  enable;
  logic [1:0]            pattern_sel;
  logic [PIXEL_SIZE-1:0] const_value;
  logic [PIXEL_SIZE-1:0] oDATA;
  logic                  oFVAL;
  logic                  oLVAL;
  logic [15:0]           oX_Cont;
  logic [15:0]           oY_Cont;
  logic [31:0]           oFrame_Cont;
  logic                  busy;

  modport master (
    input  enable, pattern_sel, const_value,
    output oDATA, oFVAL, oLVAL, oX_Cont, oY_Cont, oFrame_Cont, busy
  );

  modport slave (
    output enable, pattern_sel, const_value,
    input  oDATA, oFVAL, oLVAL, oX_Cont, oY_Cont, oFrame_Cont, busy
  );
endinterface

// File: rtl/d5m_stream_gen.sv
// Synthetic D5M raster source with ramp/checker/Bayer/constant test patterns.
// Define STREAM_GEN_LFSR_EN to turn pattern 3 into a per-frame reseeded 16-bit LFSR.
module d5m_stream_gen #(
  parameter int PIXEL_SIZE = 12,
  parameter int ACTIVE_W   = 1280,
  parameter int ACTIVE_H   = 960,
  parameter int H_BLANK    = 388,
  parameter int FV_TO_LV   = 8,
  parameter int LV_TO_FV   = 8,
  parameter int V_BLANK    = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  d5m_stream_gen_if.master sif
);

  typedef enum logic [2:0] {S_IDLE, S_LEAD, S_LINE, S_HBLK, S_TRAIL, S_VBLK} state_t;

  localparam logic [15:0] X_LAST     = 16'(ACTIVE_W - 1);
  localparam logic [15:0] Y_LAST     = 16'(ACTIVE_H - 1);
  localparam logic [15:0] HBLK_LAST  = 16'(H_BLANK - 1);
  localparam logic [15:0] LEAD_LAST  = 16'(FV_TO_LV - 1);
  localparam logic [15:0] TRAIL_LAST = 16'(LV_TO_FV - 1);
  localparam logic [15:0] VBLK_LAST  = 16'(V_BLANK - 1);
  localparam logic [PIXEL_SIZE-1:0] PIX_MAX = {PIXEL_SIZE{1'b1}};
  localparam logic [PIXEL_SIZE-1:0] PIX_MID = {1'b1, {(PIXEL_SIZE-1){1'b0}}};

  state_t                state_q, state_nx;
  logic [15:0]           cnt_q, cnt_nx;
  logic [15:0]           x_q, x_nx;
  logic [15:0]           y_q, y_nx;
  logic [31:0]           frame_q, frame_nx;
  logic [1:0]            pat_q, pat_nx;
  logic [PIXEL_SIZE-1:0] cval_q, cval_nx;
  logic                  latch;

  logic                  fval_q, fval_nx;
  logic                  lval_q, lval_nx;
  logic                  busy_q, busy_nx;
  logic [PIXEL_SIZE-1:0] data_q, data_nx;
  logic [PIXEL_SIZE-1:0] pix;

`ifdef STREAM_GEN_LFSR_EN
  logic [15:0] lfsr_q, lfsr_nx, seed;

  always_comb begin
    seed = 16'hFFFF;
    seed[PIXEL_SIZE-1:0] = sif.const_value;
    if (seed == 16'h0) seed = 16'hACE1;
    lfsr_nx = lfsr_q;
    if (latch)
      lfsr_nx = seed;
    else if (state_nx == S_LINE)
      lfsr_nx = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) lfsr_q <= 16'hACE1;
    else        lfsr_q <= lfsr_nx;
`endif

  // State register plus registered outputs: every output is a flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      frame_q <= '0;
      pat_q   <= '0;
      cval_q  <= '0;
      fval_q  <= 1'b0;
      lval_q  <= 1'b0;
      busy_q  <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_nx;
      cnt_q   <= cnt_nx;
      x_q     <= x_nx;
      y_q     <= y_nx;
      frame_q <= frame_nx;
      pat_q   <= pat_nx;
      cval_q  <= cval_nx;
      fval_q  <= fval_nx;
      lval_q  <= lval_nx;
      busy_q  <= busy_nx;
      data_q  <= data_nx;
    end
  end

  // Next state: cnt_q times the blanking phases, x_q times the active line.
  always_comb begin
    state_nx = state_q;
    cnt_nx   = cnt_q + 16'd1;
    x_nx     = '0;
    y_nx     = y_q;
    frame_nx = frame_q;
    latch    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        cnt_nx = '0;
        y_nx   = '0;
        if (sif.enable) begin
          state_nx = S_LEAD;
          latch    = 1'b1;
        end
      end
      S_LEAD:
        if (cnt_q == LEAD_LAST) begin
          state_nx = S_LINE;
          cnt_nx   = '0;
        end
      S_LINE: begin
        cnt_nx = '0;
        if (x_q == X_LAST) state_nx = (y_q == Y_LAST) ? S_TRAIL : S_HBLK;
        else               x_nx = x_q + 16'd1;
      end
      S_HBLK:
        if (cnt_q == HBLK_LAST) begin
          state_nx = S_LINE;
          cnt_nx   = '0;
          y_nx     = y_q + 16'd1;
        end
      S_TRAIL:
        if (cnt_q == TRAIL_LAST) begin
          state_nx = S_VBLK;
          cnt_nx   = '0;
          y_nx     = '0;
          frame_nx = frame_q + 32'd1;
        end
      S_VBLK:
        if (cnt_q == VBLK_LAST) begin
          cnt_nx = '0;
          if (sif.enable) begin
            state_nx = S_LEAD;
            latch    = 1'b1;
          end else begin
            state_nx = S_IDLE;
          end
        end
      default: state_nx = S_IDLE;
    endcase
    pat_nx  = latch ? sif.pattern_sel : pat_q;
    cval_nx = latch ? sif.const_value : cval_q;
  end

  // Output decode from the next state so outputs line up with the state flops.
  always_comb begin
    fval_nx = (state_nx == S_LEAD) || (state_nx == S_LINE) ||
              (state_nx == S_HBLK) || (state_nx == S_TRAIL);
    lval_nx = (state_nx == S_LINE);
    busy_nx = (state_nx != S_IDLE);
    unique case (pat_nx)
      2'd0: pix = PIXEL_SIZE'(x_nx);
      2'd1: pix = (x_nx[4] ^ y_nx[4]) ? PIX_MAX : '0;
      2'd2: begin
        unique case ({y_nx[0], x_nx[0]})
          2'b01:   pix = PIX_MAX;
          2'b10:   pix = '0;
          default: pix = PIX_MID;
        endcase
      end
`ifdef STREAM_GEN_LFSR_EN
      default: pix = lfsr_q[PIXEL_SIZE-1:0];
`else
      default: pix = cval_nx;
`endif
    endcase
    data_nx = lval_nx ? pix : '0;
  end

  assign sif.oDATA       = data_q;
  assign sif.oFVAL       = fval_q;
  assign sif.oLVAL       = lval_q;
  assign sif.oX_Cont     = x_q;
  assign sif.oY_Cont     = y_q;
  assign sif.oFrame_Cont = frame_q;
  assign sif.busy        = busy_q;

endmodule

// File: tb/tb_d5m_stream_gen.sv
// Random and directed stimulus against a position-in-frame reference model.
module tb_d5m_stream_gen;
  localparam int PS = 12, W = 8, H = 4, HB = 3, FL = 2, LF = 2, VB = 5;
  localparam int FV_LEN = FL + LF + H*W + (H-1)*HB;
  localparam int PERIOD = FV_LEN + VB;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  d5m_stream_gen_if #(.PIXEL_SIZE(PS)) sif();

  d5m_stream_gen #(
    .PIXEL_SIZE(PS), .ACTIVE_W(W), .ACTIVE_H(H), .H_BLANK(HB),
    .FV_TO_LV(FL), .LV_TO_FV(LF), .V_BLANK(VB)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .sif  (sif)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  // model: running flag, cycle position inside the frame, latched pattern
  bit          m_run = 0;
  int          m_p   = 0;
  int          m_pat = 0;
  int          m_cval = 0;
  logic [31:0] m_frames = '0;
  int          fv_run = 0, lv_run = 0;
  logic [31:0] e_fv, e_lv, e_x, e_y, e_d, e_bz;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] pix(int x, int y);
    case (m_pat)
      0: return 32'(x % 4096);
      1: return (((x/16) % 2) != ((y/16) % 2)) ? 32'hFFF : 32'h0;
      2: begin
        if ((y % 2) == 0) return ((x % 2) == 0) ? 32'h800 : 32'hFFF;
        else              return ((x % 2) == 0) ? 32'h000 : 32'h800;
      end
      default: return 32'(m_cval);
    endcase
  endfunction

  task automatic model_step();
    if (!m_run) begin
      if (sif.enable) begin
        m_run = 1; m_p = 0; m_pat = int'(sif.pattern_sel); m_cval = int'(sif.const_value);
      end
    end else begin
      m_p++;
      if (m_p == FV_LEN) m_frames++;
      if (m_p == PERIOD) begin
        if (sif.enable) begin
          m_p = 0; m_pat = int'(sif.pattern_sel); m_cval = int'(sif.const_value);
        end else begin
          m_run = 0;
        end
      end
    end
  endtask

  task automatic model_expect();
    int q, ln, col;
    e_fv = 0; e_lv = 0; e_x = 0; e_y = 0; e_d = 0; e_bz = 32'(m_run);
    if (m_run && m_p < FV_LEN) begin
      e_fv = 1;
      if (m_p >= FL) begin
        q = m_p - FL;
        if (q >= H*W + (H-1)*HB) begin
          e_y = H - 1;
        end else begin
          ln = q / (W + HB); col = q % (W + HB);
          e_y = 32'(ln);
          if (col < W) begin
            e_lv = 1; e_x = 32'(col); e_d = pix(col, ln);
          end
        end
      end
    end
  endtask

  task automatic compare();
    model_expect();
    chk("fval",  32'(sif.oFVAL), e_fv);
    chk("lval",  32'(sif.oLVAL), e_lv);
    chk("data",  32'(sif.oDATA), e_d);
    chk("x",     32'(sif.oX_Cont), e_x);
    chk("y",     32'(sif.oY_Cont), e_y);
    chk("frame", sif.oFrame_Cont, m_frames);
    chk("busy",  32'(sif.busy), e_bz);
    if (sif.oFVAL) fv_run++;
    else if (fv_run > 0) begin chk("fval_len", 32'(fv_run), FV_LEN); fv_run = 0; end
    if (sif.oLVAL) lv_run++;
    else if (lv_run > 0) begin chk("lval_len", 32'(lv_run), W); lv_run = 0; end
  endtask

  task automatic cycle();
    @(posedge clk);
    if (rst_n) model_step();
    #1;
    compare();
  endtask

  task automatic wait_p(input string tag, input int target);
    int hit = 0;
    for (int i = 0; i < 3*PERIOD; i++) begin
      if (m_run && m_p == target) begin hit = 1; break; end
      cycle();
    end
    chk(tag, 32'(hit), 1);
  endtask

  initial begin
    int lv_cnt;
    int hit;
    logic [31:0] frames_exp;
    sif.enable = 0; sif.pattern_sel = 0; sif.const_value = '0;
    #1; compare();
    repeat (2) cycle();
    rst_n = 1;
    repeat (3) cycle();

    // startup latency + geometry, ramp
    sif.enable = 1;
    cycle();
    chk("start_fval", 32'(sif.oFVAL), 1);
    repeat (2*PERIOD) cycle();

    // Bayer
    sif.pattern_sel = 2;
    wait_p("bayer_start", 0);
    repeat (PERIOD) cycle();

    // latch: constant pattern, switched to checker mid-frame
    sif.pattern_sel = 3; sif.const_value = 12'h5A5;
    wait_p("latch_start", 1);
    wait_p("latch_mid", 20);
    sif.pattern_sel = 1; sif.const_value = 12'h123;
    wait_p("latch_next", 0);
    repeat (PERIOD) cycle();

    // random controls
    for (int i = 0; i < 400; i++) begin
      sif.enable      = ($urandom_range(0, 7) != 0);
      sif.pattern_sel = 2'($urandom_range(0, 3));
      sif.const_value = 12'($urandom);
      cycle();
    end

    // graceful stop at line 1 pixel 3
    sif.enable = 1; sif.pattern_sel = 0;
    wait_p("stop_start", 1);
    wait_p("stop_drop", FL + (W + HB) + 3);
    sif.enable = 0;
    frames_exp = m_frames + 1;
    lv_cnt = 0; hit = 0;
    for (int i = 0; i < 2*PERIOD; i++) begin
      cycle();
      if (sif.oLVAL) lv_cnt++;
      if (!m_run) begin hit = 1; break; end
    end
    chk("stop_idle", 32'(hit), 1);
    repeat (3) cycle();
    chk("stop_lv_cycles", 32'(lv_cnt), 20);
    chk("stop_busy", 32'(sif.busy), 0);
    chk("stop_frames", sif.oFrame_Cont, frames_exp);

    // async reset mid-line
    sif.enable = 1;
    wait_p("rst_start", 1);
    wait_p("rst_line", FL + 2*(W + HB) + 4);
    chk("rst_pre_lval", 32'(sif.oLVAL), 1);
    #2 rst_n = 0;
    #1;
    chk("rst_fval", 32'(sif.oFVAL), 0);
    chk("rst_lval", 32'(sif.oLVAL), 0);
    chk("rst_data", 32'(sif.oDATA), 0);
    chk("rst_x", 32'(sif.oX_Cont), 0);
    chk("rst_y", 32'(sif.oY_Cont), 0);
    chk("rst_frame", sif.oFrame_Cont, 0);
    chk("rst_busy", 32'(sif.busy), 0);
    m_run = 0; m_p = 0; m_pat = 0; m_cval = 0; m_frames = '0; fv_run = 0; lv_run = 0;
    repeat (2) cycle();
    sif.enable = 0;
    rst_n = 1;
    repeat (10) cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
